// File: rtl/scope_trigger_if.sv
// ADC input, trigger controls and the display-side sample stream of scope_trigger.
// master = acquisition block, slave = ADC/display side.
interface scope_trigger_if;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig;
  logic        rising;
  logic [7:0]  decim;
  logic        full;
  logic [8:0]  sample;
  logic        valid;
  logic        triggered;
  logic        auto_fired;

  modport master (
    input  adc_data, adc_valid, trig, rising, decim, full,
    output sample, valid, triggered, auto_fired
  );

  modport slave (
    output adc_data, adc_valid, trig, rising, decim, full,
    input  sample, valid, triggered, auto_fired
  );
endinterface

// File: rtl/scope_trigger.sv
// Decimates ADC samples, triggers on a level crossing or auto timeout, streams one frame of screen rows.
// Latency 1 clk from a taken adc_valid to valid; no backpressure, a new frame is armed only after full.
module scope_trigger #(
  parameter int FRAME_LEN    = 640,
  parameter int AUTO_SAMPLES = 65535,
  parameter int HOLDOFF      = 16
) (
  input  logic            clk,
  input  logic            reset,
  scope_trigger_if.master bus
);
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int AUTO_W = $clog2(AUTO_SAMPLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_TRIG, S_CAPTURE, S_WAIT_FULL, S_HOLDOFF
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          dec_cnt;
  logic [11:0]         prev;
  logic [AUTO_W-1:0]   auto_cnt;
  logic [IDX_W-1:0]    frame_idx;
  logic [HOLD_W-1:0]   hold_cnt;

  logic active, taken, hit, auto_hit, last_idx, hold_done, emit, enter_arm;
  logic unused_adc_lsb;

  assign unused_adc_lsb = ^bus.adc_data[3:0];

  // The decimator only runs while acquiring; other states ignore adc_valid.
  assign active    = (state == S_ARM) || (state == S_WAIT_TRIG) || (state == S_CAPTURE);
  assign taken     = active && bus.adc_valid && (dec_cnt >= bus.decim);
  assign hit       = bus.rising ? ((prev < bus.trig) && (bus.adc_data >= bus.trig))
                                : ((prev > bus.trig) && (bus.adc_data <= bus.trig));
  assign auto_hit  = (auto_cnt == AUTO_W'(AUTO_SAMPLES));
  assign last_idx  = (frame_idx == IDX_W'(FRAME_LEN - 1));
  assign hold_done = (hold_cnt == HOLD_W'(HOLDOFF - 1));
  assign enter_arm = (state_nxt == S_ARM) && (state != S_ARM);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      S_IDLE:      if (bus.full) state_nxt = S_ARM;
      S_ARM:       if (taken) state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: if (taken && (hit || auto_hit)) begin
                     emit      = 1'b1;
                     state_nxt = S_CAPTURE;
                   end
      S_CAPTURE:   if (taken) begin
                     emit = 1'b1;
                     if (last_idx) state_nxt = S_WAIT_FULL;
                   end
      S_WAIT_FULL: if (bus.full) state_nxt = S_HOLDOFF;
      S_HOLDOFF:   if (hold_done) state_nxt = S_ARM;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      dec_cnt        <= '0;
      prev           <= '0;
      auto_cnt       <= '0;
      frame_idx      <= '0;
      hold_cnt       <= '0;
      bus.sample     <= '0;
      bus.valid      <= 1'b0;
      bus.triggered  <= 1'b0;
      bus.auto_fired <= 1'b0;
    end else begin
      state <= state_nxt;

      if (enter_arm)
        dec_cnt <= '0;
      else if (active && bus.adc_valid)
        dec_cnt <= taken ? 8'd0 : dec_cnt + 8'd1;

      if (taken && ((state == S_ARM) || (state == S_WAIT_TRIG)))
        prev <= bus.adc_data;

      // The arming sample counts toward the auto timeout.
      if (enter_arm)
        auto_cnt <= '0;
      else if (taken && ((state == S_ARM) || ((state == S_WAIT_TRIG) && !hit && !auto_hit)))
        auto_cnt <= auto_cnt + AUTO_W'(1);

      if (emit)
        frame_idx <= (state == S_CAPTURE && last_idx) ? '0 : frame_idx + IDX_W'(1);

      if (state == S_HOLDOFF)
        hold_cnt <= hold_done ? '0 : hold_cnt + HOLD_W'(1);
      else
        hold_cnt <= '0;

      bus.valid <= emit;
      if (emit)
        bus.sample <= 9'd300 - {1'b0, bus.adc_data[11:4]};

      // Stays high through the last frame sample's valid cycle.
      bus.triggered <= (state_nxt == S_CAPTURE) || emit;

      if (state == S_WAIT_TRIG && taken) begin
        if (hit)
          bus.auto_fired <= 1'b0;
        else if (auto_hit)
          bus.auto_fired <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scope_trigger.sv
// Directed vector table for trigger conditions plus hand sequences for frames, decimation, auto trigger and reset.
module tb_scope_trigger;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scope_trigger_if bus();

  scope_trigger #(.FRAME_LEN(640), .AUTO_SAMPLES(100), .HOLDOFF(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int vcount, first_v, last_v, min_gap, max_gap, trig_last, exp_samp, samp_bad, s;

  typedef struct {
    logic        rise;
    logic [11:0] lvl;
    logic [11:0] p;
    logic [11:0] c;
    logic        hit;
    logic [8:0]  smp;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.valid) begin
      if (vcount == 0) first_v = cyc;
      else begin
        if (cyc - last_v < min_gap) min_gap = cyc - last_v;
        if (cyc - last_v > max_gap) max_gap = cyc - last_v;
      end
      last_v = cyc;
      vcount++;
      if (exp_samp >= 0 && int'(bus.sample) != exp_samp) samp_bad++;
    end
    if (bus.triggered) trig_last = cyc;
  endtask

  task automatic clr();
    vcount = 0; samp_bad = 0; min_gap = 1000000; max_gap = 0;
    first_v = 0; last_v = 0; trig_last = 0; exp_samp = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.adc_valid = 1'b0;
    bus.full = 1'b0;
    bus.adc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
  endtask

  task automatic arm();
    bus.adc_valid = 1'b0;
    bus.full = 1'b1;
    tick();
    bus.full = 1'b0;
  endtask

  task automatic feed(input logic [11:0] d);
    bus.adc_valid = 1'b1;
    bus.adc_data = d;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    bus.rising = 1'b1; bus.trig = 12'h800; bus.decim = 8'd0;
    bus.adc_valid = 1'b0; bus.adc_data = '0; bus.full = 1'b0;

    vecs[0]  = '{1'b1, 12'h800, 12'h7FF, 12'h800, 1'b1, 9'd172};
    vecs[1]  = '{1'b1, 12'h800, 12'h800, 12'h900, 1'b0, 9'd0};
    vecs[2]  = '{1'b1, 12'h800, 12'h800, 12'h800, 1'b0, 9'd0};
    vecs[3]  = '{1'b1, 12'h400, 12'h3FF, 12'h500, 1'b1, 9'd220};
    vecs[4]  = '{1'b0, 12'h400, 12'h500, 12'h3FF, 1'b1, 9'd237};
    vecs[5]  = '{1'b0, 12'h400, 12'h3FF, 12'h500, 1'b0, 9'd0};
    vecs[6]  = '{1'b0, 12'h400, 12'h401, 12'h400, 1'b1, 9'd236};
    vecs[7]  = '{1'b1, 12'h000, 12'h000, 12'hFFF, 1'b0, 9'd0};
    vecs[8]  = '{1'b0, 12'hFFF, 12'hFFF, 12'h000, 1'b0, 9'd0};
    vecs[9]  = '{1'b1, 12'hFFF, 12'hFFE, 12'hFFF, 1'b1, 9'd45};
    vecs[10] = '{1'b0, 12'h100, 12'h200, 12'h000, 1'b1, 9'd300};

    do_reset();
    chk("reset_valid", bus.valid, 0);
    chk("reset_sample", bus.sample, 0);
    chk("reset_triggered", bus.triggered, 0);
    chk("reset_auto_fired", bus.auto_fired, 0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      bus.rising = vecs[i].rise;
      bus.trig = vecs[i].lvl;
      arm();
      feed(vecs[i].p);
      feed(vecs[i].c);
      bus.adc_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), bus.valid, vecs[i].hit);
      chk($sformatf("vec%0d_triggered", i), bus.triggered, vecs[i].hit);
      if (vecs[i].hit) chk($sformatf("vec%0d_sample", i), bus.sample, vecs[i].smp);
    end

    // Rising ramp, full frame, WAIT_FULL silence, holdoff length
    do_reset();
    bus.rising = 1'b1; bus.trig = 12'h800; bus.decim = 8'd0;
    arm();
    for (int i = 0; i < 17; i++) feed(12'h7F0 + 12'(i));
    chk("ramp_first_count", vcount, 1);
    chk("ramp_first_sample", bus.sample, 172);
    chk("ramp_first_triggered", bus.triggered, 1);
    for (int i = 0; i < 750; i++) feed(12'h800);
    chk("ramp_frame_count", vcount, 640);
    chk("ramp_frame_span", last_v - first_v, 639);
    chk("ramp_triggered_fall", trig_last, last_v);
    chk("ramp_triggered_low", bus.triggered, 0);
    arm();
    for (int i = 0; i < 16; i++) feed(12'h000);
    chk("holdoff_quiet", vcount, 640);
    feed(12'h7FF);
    chk("holdoff_not_short", vcount, 640);
    feed(12'h800);
    chk("holdoff_rearm_count", vcount, 641);
    chk("holdoff_rearm_sample", bus.sample, 172);

    // decim=3
    do_reset();
    bus.decim = 8'd3;
    arm();
    s = cyc;
    for (int i = 0; i < 2700; i++) feed(i < 20 ? 12'h000 : 12'hFFF);
    chk("decim_count", vcount, 640);
    chk("decim_min_gap", min_gap, 4);
    chk("decim_max_gap", max_gap, 4);
    chk("decim_first_at", first_v - s, 24);
    chk("decim_span", last_v - first_v, 2556);
    bus.decim = 8'd0;

    // Auto trigger on constant input
    do_reset();
    arm();
    s = cyc;
    exp_samp = 282;
    for (int i = 0; i < 800; i++) feed(12'h123);
    chk("auto_first_at", first_v - s, 101);
    chk("auto_count", vcount, 640);
    chk("auto_bad_samples", samp_bad, 0);
    chk("auto_fired_set", bus.auto_fired, 1);
    exp_samp = -1;
    arm();
    repeat (16) tick();
    chk("auto_fired_held", bus.auto_fired, 1);
    feed(12'h7FF);
    feed(12'h800);
    chk("auto_real_valid", bus.valid, 1);
    chk("auto_fired_cleared", bus.auto_fired, 0);

    // A real hit on the timeout sample wins
    do_reset();
    arm();
    for (int i = 0; i < 100; i++) feed(12'h7FF);
    chk("hitwins_no_early", vcount, 0);
    feed(12'h800);
    chk("hitwins_valid", bus.valid, 1);
    chk("hitwins_auto_fired", bus.auto_fired, 0);
    chk("hitwins_sample", bus.sample, 172);

    // full held low
    do_reset();
    for (int i = 0; i < 200; i++) feed((i % 2) ? 12'hFFF : 12'h000);
    chk("nofull_count", vcount, 0);
    arm();
    feed(12'h7FF);
    feed(12'h800);
    chk("nofull_then_count", vcount, 1);
    chk("nofull_then_triggered", bus.triggered, 1);

    // Reset mid-capture
    do_reset();
    arm();
    feed(12'h7FF);
    feed(12'h800);
    for (int i = 0; i < 400 && vcount < 301; i++) feed(12'h900);
    chk("midreset_reach_idx300", vcount, 301);
    reset = 1'b1;
    #1;
    chk("midreset_valid", bus.valid, 0);
    chk("midreset_triggered", bus.triggered, 0);
    chk("midreset_sample", bus.sample, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    arm();
    feed(12'h7FF);
    for (int i = 0; i < 700; i++) feed(12'h800);
    chk("midreset_next_frame", vcount, 640);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
